// File: rtl/julia_scan_ctrl_pkg.sv
// Shared fixed-point constants, FSM state encoding and scaling helper for the Julia scanner.
// Optional abort input of julia_scan_ctrl is enabled by defining JULIA_ABORT_EN.
package julia_pkg;

    localparam int JL_W       = 32;
    localparam int JL_PW      = 64;
    localparam int JL_FRAC    = 10;
    localparam logic signed [JL_PW-1:0] JL_MUL = 64'sd1024;
    localparam logic [JL_PW-1:0] ESC_R2 = 64'd4194304;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    // Rescale a 64-bit product back to 32-bit fixed point; signed divide truncates toward zero.
    function automatic logic signed [JL_W-1:0] fx_div(input logic signed [JL_PW-1:0] v);
        logic signed [JL_PW-1:0] q;
        q = v / JL_MUL;
        fx_div = q[JL_W-1:0];
    endfunction

endpackage

// File: rtl/julia_scan_ctrl_step.sv
// One combinational Julia iteration z' = z^2 + c, plus |z'|^2 for the escape test.
module julia_step
    import julia_pkg::*;
(
    input  logic signed [JL_W-1:0] wx,
    input  logic signed [JL_W-1:0] wy,
    input  logic signed [JL_W-1:0] cr,
    input  logic signed [JL_W-1:0] ci,
    output logic signed [JL_W-1:0] wx_next,
    output logic signed [JL_W-1:0] wy_next,
    output logic [JL_PW-1:0]       mag2
);

    logic signed [JL_PW-1:0] wx64_s;
    logic signed [JL_PW-1:0] wy64_s;
    logic signed [JL_PW-1:0] nx64_s;
    logic signed [JL_PW-1:0] ny64_s;
    logic signed [JL_PW-1:0] sqx_s;
    logic signed [JL_PW-1:0] sqy_s;

    // Squares of z' are non-negative, so summing them unsigned cannot wrap.
    always_comb begin
        wx64_s  = $signed({{32{wx[31]}}, wx});
        wy64_s  = $signed({{32{wy[31]}}, wy});
        wx_next = fx_div(wx64_s * wx64_s - wy64_s * wy64_s) + cr;
        wy_next = fx_div(64'sd2 * wx64_s * wy64_s) + ci;
        nx64_s  = $signed({{32{wx_next[31]}}, wx_next});
        ny64_s  = $signed({{32{wy_next[31]}}, wy_next});
        sqx_s   = nx64_s * nx64_s;
        sqy_s   = ny64_s * ny64_s;
        mag2    = $unsigned(sqx_s) + $unsigned(sqy_s);
    end

endmodule

// File: rtl/julia_scan_ctrl.sv
// Raster-scan Julia set controller: iterates each pixel and streams its escape count.
// Define JULIA_ABORT_EN to add the abort input that cancels a frame in progress.
module julia_scan_ctrl
    import julia_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int MAX_ITER = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [31:0]     cr,
    input  logic signed [31:0]     ci,
    input  logic signed [31:0]     x0,
    input  logic signed [31:0]     y0,
    input  logic signed [31:0]     step,
    input  logic                   pix_ready,
`ifdef JULIA_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   pix_valid,
    output logic [15:0]            pix_x,
    output logic [15:0]            pix_y,
    output logic [7:0]             pix_iter
);

    localparam logic [2:0]  S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0]  S_LOAD   = 3'(ST_LOAD);
    localparam logic [2:0]  S_ITER   = 3'(ST_ITER);
    localparam logic [2:0]  S_EMIT   = 3'(ST_EMIT);
    localparam logic [2:0]  S_FIN    = 3'(ST_FIN);
    localparam logic [7:0]  ITER_CAP = 8'(MAX_ITER);
    localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);

    logic [2:0]         state_r;
    logic               busy_r;
    logic               done_r;
    logic               pix_valid_r;
    logic [15:0]        pix_x_r;
    logic [15:0]        pix_y_r;
    logic [7:0]         pix_iter_r;
    logic [15:0]        px_r;
    logic [15:0]        py_r;
    logic [7:0]         iter_r;
    logic signed [31:0] cr_r;
    logic signed [31:0] ci_r;
    logic signed [31:0] x0_r;
    logic signed [31:0] y0_r;
    logic signed [31:0] step_r;
    logic signed [31:0] wx_r;
    logic signed [31:0] wy_r;

    logic signed [31:0] wx_next_s;
    logic signed [31:0] wy_next_s;
    logic [63:0]        mag2_s;
    logic signed [31:0] lx_s;
    logic signed [31:0] ly_s;
    logic [7:0]         iter_inc_s;
    logic               stop_s;
    logic               hs_s;
    logic               abort_s;

    julia_step u_step (
        .wx      (wx_r),
        .wy      (wy_r),
        .cr      (cr_r),
        .ci      (ci_r),
        .wx_next (wx_next_s),
        .wy_next (wy_next_s),
        .mag2    (mag2_s)
    );

    // Pixel start coordinate, iteration stop condition, handshake and abort qualification.
    always_comb begin
        lx_s       = x0_r + $signed({16'd0, px_r}) * step_r;
        ly_s       = y0_r + $signed({16'd0, py_r}) * step_r;
        iter_inc_s = iter_r + 8'd1;
        stop_s     = (mag2_s > ESC_R2) || (iter_inc_s == ITER_CAP);
        hs_s       = (state_r == S_EMIT) && pix_ready;
`ifdef JULIA_ABORT_EN
        abort_s    = abort && (state_r != S_IDLE);
`else
        abort_s    = 1'b0;
`endif
    end

    // Frame sequencer: all state, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_x_r     <= 16'd0;
            pix_y_r     <= 16'd0;
            pix_iter_r  <= 8'd0;
            px_r        <= 16'd0;
            py_r        <= 16'd0;
            iter_r      <= 8'd0;
            cr_r        <= 32'sd0;
            ci_r        <= 32'sd0;
            x0_r        <= 32'sd0;
            y0_r        <= 32'sd0;
            step_r      <= 32'sd0;
            wx_r        <= 32'sd0;
            wy_r        <= 32'sd0;
        end else if (abort_s) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pix_valid_r <= 1'b0;
            px_r        <= 16'd0;
            py_r        <= 16'd0;
            iter_r      <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cr_r    <= cr;
                        ci_r    <= ci;
                        x0_r    <= x0;
                        y0_r    <= y0;
                        step_r  <= step;
                        px_r    <= 16'd0;
                        py_r    <= 16'd0;
                        busy_r  <= 1'b1;
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wx_r    <= lx_s;
                    wy_r    <= ly_s;
                    iter_r  <= 8'd0;
                    state_r <= S_ITER;
                end
                S_ITER: begin
                    wx_r   <= wx_next_s;
                    wy_r   <= wy_next_s;
                    iter_r <= iter_inc_s;
                    if (stop_s) begin
                        pix_valid_r <= 1'b1;
                        pix_x_r     <= px_r;
                        pix_y_r     <= py_r;
                        pix_iter_r  <= iter_inc_s;
                        state_r     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (hs_s) begin
                        pix_valid_r <= 1'b0;
                        if (px_r != X_LAST) begin
                            px_r    <= px_r + 16'd1;
                            state_r <= S_LOAD;
                        end else begin
                            px_r <= 16'd0;
                            if (py_r != Y_LAST) begin
                                py_r    <= py_r + 16'd1;
                                state_r <= S_LOAD;
                            end else begin
                                done_r  <= 1'b1;
                                state_r <= S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    pix_valid_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pix_valid = pix_valid_r;
    assign pix_x     = pix_x_r;
    assign pix_y     = pix_y_r;
    assign pix_iter  = pix_iter_r;

endmodule

// File: tb/tb_julia_scan_ctrl.sv
// Directed bench: a 1x1 instance for latency/edge cases and a 4x2 instance for raster order.
module tb_julia_scan_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [31:0] cr = 32'sd0, ci = 32'sd0, x0 = 32'sd0, y0 = 32'sd0, step = 32'sd0;
    logic start_a = 1'b0, start_b = 1'b0, ready_a = 1'b0, ready_b = 1'b0;
`ifdef JULIA_ABORT_EN
    logic abort_a = 1'b0, abort_b = 1'b0;
`endif
    logic busy_a, done_a, valid_a, busy_b, done_b, valid_b;
    logic [15:0] x_a, y_a, x_b, y_b;
    logic [7:0] iter_a, iter_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    julia_scan_ctrl #(.WIDTH(1), .HEIGHT(1), .MAX_ITER(255)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cr(cr), .ci(ci), .x0(x0), .y0(y0),
        .step(step), .pix_ready(ready_a),
`ifdef JULIA_ABORT_EN
        .abort(abort_a),
`endif
        .busy(busy_a), .done(done_a), .pix_valid(valid_a),
        .pix_x(x_a), .pix_y(y_a), .pix_iter(iter_a)
    );

    julia_scan_ctrl #(.WIDTH(4), .HEIGHT(2), .MAX_ITER(255)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cr(cr), .ci(ci), .x0(x0), .y0(y0),
        .step(step), .pix_ready(ready_b),
`ifdef JULIA_ABORT_EN
        .abort(abort_b),
`endif
        .busy(busy_b), .done(done_b), .pix_valid(valid_b),
        .pix_x(x_b), .pix_y(y_b), .pix_iter(iter_b)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy_a, done_a, valid_a, x_a, y_a, iter_a} !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_a: got %h want 0", {busy_a, done_a, valid_a, x_a, y_a, iter_a});
        end
        n_cmp++;
        if ({busy_b, done_b, valid_b, x_b, y_b, iter_b} !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_b: got %h want 0", {busy_b, done_b, valid_b, x_b, y_b, iter_b});
        end
    endtask

    // Start right at reset release; z stays at the origin so the cap is reached.
    task automatic test_single_cap();
        int cyc;
        @(posedge clk); #1;
        reset = 1'b0; start_a = 1'b1; ready_a = 1'b1;
        cr = 32'sd0; ci = 32'sd0; x0 = 32'sd0; y0 = 32'sd0; step = 32'sd0;
        @(posedge clk); #1;
        start_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b1) begin n_bad++; $display("FAIL start_after_reset: busy=%b want 1", busy_a); end
        cyc = 0;
        @(negedge clk);
        while (!valid_a && cyc < 400) begin @(negedge clk); cyc++; end
        n_cmp++;
        if ({valid_a, x_a, y_a, iter_a} !== {1'b1, 16'd0, 16'd0, 8'd255}) begin
            n_bad++;
            $display("FAIL cap_beat: valid=%b x=%0d y=%0d iter=%0d want 1/0/0/255", valid_a, x_a, y_a, iter_a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done_a, valid_a, busy_a} !== 3'b101) begin
            n_bad++;
            $display("FAIL done_after_hs: done/valid/busy=%b want 101", {done_a, valid_a, busy_a});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done_a, busy_a} !== 2'b00) begin
            n_bad++;
            $display("FAIL fin_exit: done/busy=%b want 00", {done_a, busy_a});
        end
    endtask

    // z0 = 3 escapes after one step: exact latency start -> LOAD -> ITER -> EMIT.
    task automatic test_escape();
        x0 = 32'sd3072;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (valid_a !== 1'b0) begin n_bad++; $display("FAIL esc_early: valid=%b want 0", valid_a); end
        @(negedge clk);
        n_cmp++;
        if ({valid_a, iter_a} !== {1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL esc_iter: valid=%b iter=%0d want 1/1", valid_a, iter_a);
        end
        repeat (3) @(negedge clk);
        x0 = 32'sd0;
    endtask

    // Stall the first beat, then stream a 4x2 frame with a stray start mid-frame.
    task automatic test_raster_stall();
        logic [7:0] exp_iter [8];
        int k, dones, cyc;
        logic [15:0] sx, sy;
        logic [7:0] si;
        logic stable;
        exp_iter = '{8'd255, 8'd255, 8'd1, 8'd1, 8'd255, 8'd2, 8'd1, 8'd1};
        step = 32'sd1024; ready_b = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!valid_b && cyc < 600) begin @(negedge clk); cyc++; end
        sx = x_b; sy = y_b; si = iter_b; stable = valid_b;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!valid_b || x_b !== sx || y_b !== sy || iter_b !== si) stable = 1'b0;
        end
        n_cmp++;
        if (!stable || sx !== 16'd0 || sy !== 16'd0) begin
            n_bad++;
            $display("FAIL stall_hold: stable=%b x=%0d y=%0d want 1/0/0", stable, sx, sy);
        end
        ready_b = 1'b1;
        k = 0; dones = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (valid_b) begin
                n_cmp++;
                if (k >= 8 || x_b !== 16'(k % 4) || y_b !== 16'(k / 4) || iter_b !== exp_iter[k % 8]) begin
                    n_bad++;
                    $display("FAIL beat%0d: x=%0d y=%0d iter=%0d", k, x_b, y_b, iter_b);
                end
                k++;
            end
            if (done_b) dones++;
            if (!busy_b) break;
            start_b = (cyc == 50);
            @(negedge clk);
        end
        start_b = 1'b0;
        n_cmp++;
        if (k != 8 || dones != 1 || busy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_end: beats=%0d dones=%0d busy=%b want 8/1/0", k, dones, busy_b);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy_b !== 1'b0) begin n_bad++; $display("FAIL stray_start: busy=%b want 0", busy_b); end
    endtask

`ifdef JULIA_ABORT_EN
    task automatic test_abort();
        int cyc, dones;
        ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!(valid_b && x_b == 16'd1) && cyc < 1000) begin @(negedge clk); cyc++; end
        @(posedge clk);
        @(posedge clk); #1;
        abort_b = 1'b1;
        @(posedge clk); #1;
        abort_b = 1'b0;
        n_cmp++;
        if ({busy_b, valid_b, done_b} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_exit: busy/valid/done=%b want 000", {busy_b, valid_b, done_b});
        end
        dones = 0;
        repeat (5) begin @(negedge clk); if (done_b || busy_b) dones++; end
        n_cmp++;
        if (dones != 0) begin n_bad++; $display("FAIL abort_quiet: activity=%0d want 0", dones); end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!valid_b && cyc < 600) begin @(negedge clk); cyc++; end
        n_cmp++;
        if ({valid_b, x_b, y_b, iter_b} !== {1'b1, 16'd0, 16'd0, 8'd255}) begin
            n_bad++;
            $display("FAIL abort_restart: valid=%b x=%0d y=%0d iter=%0d", valid_b, x_b, y_b, iter_b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_cap();
        test_escape();
        test_raster_stall();
`ifdef JULIA_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/julia_scan_ctrl.md
JULIA_SCAN_CTRL -- requirements
Module: julia_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640: pixels per row, 1..65535.
REQ-002 SHALL have parameter HEIGHT, default 480: rows per frame, 1..65535.
REQ-003 SHALL have parameter MAX_ITER, default 255: iteration cap, 1..255.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  start  in  1  frame request
  cr, ci  in  32 signed  Julia constant, fixed point
  x0, y0  in  32 signed  pixel (0,0) coordinate, fixed point
  step  in  32 signed  coordinate increment per pixel
  busy  out  1  frame in progress
  done  out  1  one-cycle end-of-frame pulse
  pix_valid  out  1  result beat valid
  pix_ready  in  1  downstream accepts beat
  pix_x, pix_y  out  16  pixel position
  pix_iter  out  8  iteration count

Function
REQ-005 SHALL use fixed point scaled by JL_MUL (1024); all products SHALL be formed at 64 bits; division by JL_MUL SHALL truncate toward zero.
REQ-006 SHALL accept start only in IDLE and SHALL sample cr, ci, x0, y0 and step on acceptance; start outside IDLE SHALL be ignored.
REQ-007 SHALL implement states IDLE, LOAD, ITER, EMIT, FIN.
REQ-008 IDLE -> LOAD on accepted start; busy SHALL be 1 from the next cycle until FIN exits.
REQ-009 LOAD (1 cycle): z = (x0 + px*step, y0 + py*step), with 32-bit wrap; iter = 0; -> ITER.
REQ-010 ITER (1 cycle per step): wx' = (wx*wx - wy*wy)/JL_MUL + cr; wy' = (2*wx*wy)/JL_MUL + ci; iter += 1.
REQ-011 ITER -> EMIT when wx'^2 + wy'^2 > 4*JL_MUL^2 (strict) or iter reaches MAX_ITER; otherwise remain in ITER.
REQ-012 EMIT SHALL hold pix_valid = 1, pix_x = px, pix_y = py and pix_iter = iter (1..MAX_ITER) stable until the pix_valid && pix_ready cycle.
REQ-013 On handshake: if px < WIDTH-1, px += 1 -> LOAD; else px = 0; if py < HEIGHT-1, py += 1 -> LOAD; else -> FIN.
REQ-014 Scan order SHALL be raster: x fastest.
REQ-015 FIN (1 cycle) SHALL assert done, then -> IDLE with busy = 0.
REQ-016 pix_ready SHALL be ignored outside EMIT; pix_valid SHALL never drop without a handshake, except as given in REQ-021.

Reset
REQ-017 reset SHALL force IDLE asynchronously and clear busy, done, pix_valid, pix_x, pix_y, pix_iter, px, py, iter and the sampled registers to 0.
REQ-018 reset mid-frame SHALL discard the frame without a done pulse; the first post-reset start SHALL begin at pixel (0,0).

Configuration
REQ-019 Macro JULIA_ABORT_EN SHALL gate the abort feature.
REQ-020 Without JULIA_ABORT_EN, no abort port SHALL exist and behaviour SHALL be as above.
REQ-021 With JULIA_ABORT_EN, input port abort (1 bit) SHALL exist; abort = 1 in any non-IDLE state SHALL move to IDLE on the next edge with busy = 0 and pix_valid = 0, without a done pulse.
REQ-022 With JULIA_ABORT_EN, abort SHALL take priority over a simultaneous handshake; the beat SHALL count as not accepted. abort in IDLE SHALL be ignored.

Structure
REQ-023 Shared package julia_pkg SHALL hold JL_MUL, the escape constant ESC_R2 = 4*JL_MUL^2, the state enum and fixed-point width constants.
REQ-024 The iteration datapath SHALL be sub-module julia_step: combinational wx', wy' and |z'|^2 from wx, wy, cr, ci; the controller SHALL own all registers.

Verification
REQ-025 Assert reset, release it -> all outputs 0; start ignored for 0 cycles after release (accepted immediately).
REQ-026 WIDTH=1, HEIGHT=1, cr=ci=0, x0=y0=0, pix_ready=1 -> one beat (0,0) with pix_iter=MAX_ITER (255); done one cycle after the handshake.
REQ-027 x0=3072, y0=0, cr=ci=0 -> first step wx'=9216, wy'=0, res=84934656 > 4194304 -> pix_iter=1.
REQ-028 pix_ready held 0 for 10 cycles in EMIT -> pix_valid, pix_x, pix_y and pix_iter are stable; no LOAD occurs until ready.
REQ-029 WIDTH=4, HEIGHT=2 -> 8 beats in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); a start during busy has no effect; exactly one done pulse.
REQ-030 (JULIA_ABORT_EN) abort in ITER at pixel (2,0) -> busy=0 and pix_valid=0 next cycle, no done pulse; the next start begins at (0,0).
